bg_layer_sequencer: RTL and testbench

BG_LAYER_SEQUENCER -- requirements
Module: bg_layer_sequencer

---
 rtl/bg_pkg.sv | 29 ++
 rtl/bg_priority_mux.sv | 45 ++++
 rtl/bg_layer_sequencer.sv | 101 ++++++++++
 tb/tb_bg_layer_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared defaults and helpers for the background layer sequencer.
package bg_pkg;

    localparam int BG_NUM_LAYERS = 4;
    localparam int BG_PAN_W      = 5;
    localparam int BG_STAGGER    = 2;

    localparam int BG_MAX_LAYERS = 8;
    localparam int BG_MAX_PAN_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Extracts layer idx's pan from a packed pan vector (zero-extended).
    function automatic logic [BG_MAX_PAN_W-1:0] pan_slice(
        input logic [BG_MAX_LAYERS*BG_MAX_PAN_W-1:0] pans,
        input int                                    idx,
        input int                                    pan_w
    );
        logic [BG_MAX_LAYERS*BG_MAX_PAN_W-1:0] shifted;
        logic [BG_MAX_PAN_W-1:0]               mask;
        shifted = pans >> (idx * pan_w);
        mask    = BG_MAX_PAN_W'((32'd1 << pan_w) - 32'd1);
        return shifted[BG_MAX_PAN_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/bg_priority_mux.sv
// Registered priority compositor: lowest-index enabled layer with a set pixel wins.
module bg_priority_mux #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_LAYERS-1:0] enable,
    input  logic [NUM_LAYERS-1:0] pixel_in,
    output logic                  pixel_out,
    output logic [IDX_W-1:0]      pixel_layer,
    output logic                  pixel_valid
);

    logic [NUM_LAYERS-1:0] hit;
    logic                  valid_d, valid_q;
    logic [IDX_W-1:0]      layer_d, layer_q;

    always_comb begin
        hit     = enable & pixel_in;
        valid_d = |hit;
        layer_d = '0;
        // Scan from the top so the lowest set index is the last one written.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                layer_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            layer_q <= '0;
        end else begin
            valid_q <= valid_d;
            layer_q <= layer_d;
        end
    end

    assign pixel_out   = valid_q;
    assign pixel_layer = layer_q;
    assign pixel_valid = valid_q;

endmodule

// File: rtl/bg_layer_sequencer.sv
// Staggers per-layer line-start pulses, shadows enable/pan per line, and composites pixels.
module bg_layer_sequencer
    import bg_pkg::*;
#(
    parameter int NUM_LAYERS = BG_NUM_LAYERS,
    parameter int PAN_W      = BG_PAN_W,
    parameter int STAGGER    = BG_STAGGER
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          lineStarting,
    input  logic [NUM_LAYERS-1:0]         layerEnable,
    input  logic [NUM_LAYERS*PAN_W-1:0]   layerPan,
    input  logic [NUM_LAYERS-1:0]         layerPixelIn,
    output logic [NUM_LAYERS-1:0]         layerStartOut,
    output logic [NUM_LAYERS*PAN_W-1:0]   layerPanOut,
    output logic                          busy,
    output logic                          overrun,
    output logic                          pixelOut,
    output logic [$clog2(NUM_LAYERS)-1:0] pixelLayer,
    output logic                          pixelValid
);

    localparam int CNT_W = $clog2(NUM_LAYERS * STAGGER + 1);
    localparam int LAST  = (NUM_LAYERS - 1) * STAGGER;

    seq_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_LAYERS-1:0]       shadow_en_q, shadow_en_d;
    logic [NUM_LAYERS*PAN_W-1:0] shadow_pan_q, shadow_pan_d;
    logic                        overrun_q, overrun_d;
    logic                        final_slot;
    logic                        accept;

    assign final_slot = (state_q == ST_RUN) && (cnt_q == CNT_W'(LAST));
    assign accept     = lineStarting && ((state_q == ST_IDLE) || final_slot);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_en_d  = shadow_en_q;
        shadow_pan_d = shadow_pan_q;
        overrun_d    = lineStarting && !accept;
        if (accept) begin
            state_d      = ST_RUN;
            cnt_d        = '0;
            shadow_en_d  = layerEnable;
            shadow_pan_d = layerPan;
        end else if (state_q == ST_RUN) begin
            if (final_slot) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shadow_en_q  <= '0;
            shadow_pan_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_en_q  <= shadow_en_d;
            shadow_pan_q <= shadow_pan_d;
            overrun_q    <= overrun_d;
        end
    end

    // Each layer owns the slot where the counter equals i*STAGGER; disabled layers stay silent.
    always_comb begin
        layerStartOut = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layerStartOut[i] = (state_q == ST_RUN) && (cnt_q == CNT_W'(i * STAGGER))
                               && shadow_en_q[i];
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign overrun     = overrun_q;
    assign layerPanOut = shadow_pan_q;

    bg_priority_mux #(
        .NUM_LAYERS(NUM_LAYERS),
        .IDX_W     ($clog2(NUM_LAYERS))
    ) u_mux (
        .clk        (clk),
        .reset      (reset),
        .enable     (shadow_en_q),
        .pixel_in   (layerPixelIn),
        .pixel_out  (pixelOut),
        .pixel_layer(pixelLayer),
        .pixel_valid(pixelValid)
    );

endmodule

// File: tb/tb_bg_layer_sequencer.sv
// Directed plus randomized bench for bg_layer_sequencer with a time-based reference model.
module tb_bg_layer_sequencer;

    localparam int NL   = 4;
    localparam int PW   = 5;
    localparam int S    = 2;
    localparam int LAST = (NL - 1) * S;
    localparam int IW   = $clog2(NL);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           lineStarting = 1'b0;
    logic [NL-1:0]  layerEnable = '0;
    logic [NL*PW-1:0] layerPan = '0;
    logic [NL-1:0]  layerPixelIn = '0;
    logic [NL-1:0]  layerStartOut;
    logic [NL*PW-1:0] layerPanOut;
    logic           busy;
    logic           overrun;
    logic           pixelOut;
    logic [IW-1:0]  pixelLayer;
    logic           pixelValid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: time of last accepted line plus the values it captured.
    int               t_acc = -1000;
    logic [NL-1:0]    m_en = '0;
    logic [NL*PW-1:0] m_pan = '0;
    logic             m_ovr = 1'b0;
    logic             m_pv = 1'b0;
    logic [IW-1:0]    m_pl = '0;

    bg_layer_sequencer #(.NUM_LAYERS(NL), .PAN_W(PW), .STAGGER(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .lineStarting (lineStarting),
        .layerEnable  (layerEnable),
        .layerPan     (layerPan),
        .layerPixelIn (layerPixelIn),
        .layerStartOut(layerStartOut),
        .layerPanOut  (layerPanOut),
        .busy         (busy),
        .overrun      (overrun),
        .pixelOut     (pixelOut),
        .pixelLayer   (pixelLayer),
        .pixelValid   (pixelValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic in_run(input int c);
        return (c >= t_acc + 1) && (c <= t_acc + 1 + LAST);
    endfunction

    task automatic check_outputs();
        logic [NL-1:0] exp_start;
        exp_start = '0;
        for (int i = 0; i < NL; i++) begin
            if (in_run(cyc) && (cyc == t_acc + 1 + i * S) && m_en[i]) exp_start[i] = 1'b1;
        end
        chk("start", 32'(layerStartOut), 32'(exp_start));
        chk("busy", 32'(busy), 32'(in_run(cyc)));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("pan_out", 32'(layerPanOut), 32'(m_pan));
        chk("pix_out", 32'(pixelOut), 32'(m_pv));
        chk("pix_layer", 32'(pixelLayer), 32'(m_pl));
        chk("pix_valid", 32'(pixelValid), 32'(m_pv));
    endtask

    task automatic check_all_zero();
        chk("rst_start", 32'(layerStartOut), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_pan_out", 32'(layerPanOut), 32'd0);
        chk("rst_pix_out", 32'(pixelOut), 32'd0);
        chk("rst_pix_layer", 32'(pixelLayer), 32'd0);
        chk("rst_pix_valid", 32'(pixelValid), 32'd0);
    endtask

    // One clock cycle: drive, check mid-cycle, optionally pulse reset, advance the model.
    task automatic step(input logic ls, input logic rp);
        logic acc;
        logic [NL-1:0] hit;
        lineStarting = ls;
        @(negedge clk);
        check_outputs();
        if (rp) begin
            reset = 1'b1;
            #1;
            check_all_zero();
            t_acc = -1000;
            m_en  = '0;
            m_pan = '0;
            m_ovr = 1'b0;
            m_pv  = 1'b0;
            m_pl  = '0;
            reset = 1'b0;
        end
        hit  = m_en & layerPixelIn;
        m_pv = |hit;
        m_pl = '0;
        for (int i = 0; i < NL; i++) begin
            if (hit[i]) begin
                m_pl = IW'(i);
                break;
            end
        end
        acc   = ls && (!in_run(cyc) || (cyc == t_acc + 1 + LAST));
        m_ovr = ls && !acc;
        if (acc) begin
            t_acc = cyc;
            m_en  = layerEnable;
            m_pan = layerPan;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    initial begin
        int base;
        logic [NL*PW-1:0] captured;

        // Reset state
        #2;
        check_all_zero();
        @(posedge clk);
        #1;
        step(1'b0, 1'b1);

        // Full enable, line at cycle 10
        layerEnable = 4'hF;
        layerPan    = {5'd3, 5'd2, 5'd1, 5'd0};
        while (cyc < 10) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(10);

        // Sparse enable: disabled layers still consume their slots
        layerEnable = 4'b0101;
        step(1'b1, 1'b0);
        idle(10);

        // Overrun mid-sequence, then back-to-back accept on the final slot
        layerEnable = 4'hF;
        step(1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0);
        idle(3);
        layerPan = {5'd7, 5'd6, 5'd5, 5'd4};
        step(1'b1, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd1);
        idle(10);

        // Pan changes mid-sequence do not disturb the shadowed values
        layerPan = {5'd3, 5'd2, 5'd1, 5'd0};
        step(1'b1, 1'b0);
        captured = {5'd3, 5'd2, 5'd1, 5'd0};
        step(1'b0, 1'b0);
        layerPan    = {NL{5'd31}};
        layerEnable = 4'h0;
        idle(4);
        chk("pan_hold", 32'(layerPanOut), 32'(captured));
        idle(6);
        layerEnable = 4'hF;
        step(1'b1, 1'b0);
        chk("pan_new", 32'(layerPanOut), 32'(layerPan));

        // Compositing priority
        layerPixelIn = 4'b1100;
        step(1'b0, 1'b0);
        chk("pix_1100_layer", 32'(pixelLayer), 32'd2);
        chk("pix_1100_valid", 32'(pixelValid), 32'd1);
        layerPixelIn = 4'b0000;
        step(1'b0, 1'b0);
        chk("pix_0000_valid", 32'(pixelValid), 32'd0);
        layerPixelIn = 4'b1011;
        idle(10);

        // Reset aborts a running sequence; first edge after release can accept
        layerPan = {5'd3, 5'd2, 5'd1, 5'd0};
        base = cyc;
        step(1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1);
        idle(5);
        step(1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b1);
        chk("post_rst_accept", 32'(busy), 32'd1);
        idle(9);

        // Randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            layerEnable  = NL'($urandom);
            layerPan     = (NL*PW)'({$urandom, $urandom});
            layerPixelIn = NL'($urandom);
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
        end

        if (base < 0) failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
